// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL window feeding a TX FIFO and serialiser.
// Optional interrupt output and CTRL register enabled by defining MMIO_UART_TX_IRQ_EN.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_data_out,
  input  logic        memory_write_enable,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        uart_tx,
  output logic        tx_busy
`ifdef MMIO_UART_TX_IRQ_EN
  ,
  output logic        tx_irq
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] OFF_TXDATA = 2'b00;
  localparam logic [1:0] OFF_STATUS = 2'b01;
  localparam logic [1:0] OFF_CTRL   = 2'b10;

  // Bus decode
  logic [1:0] offset;
  logic       wr_txdata;
  logic       wr_txdata_q;
  logic       wr_status;
  logic       push_req;

  assign offset    = memory_address[3:2];
  assign hit       = (memory_address[31:4] == BASE_ADDR[31:4]) && (offset != 2'b11);
  assign wr_txdata = hit && memory_write_enable && (offset == OFF_TXDATA);
  assign wr_status = hit && memory_write_enable && (offset == OFF_STATUS);

  // A multi-cycle store strobe must enqueue exactly one byte.
  assign push_req = wr_txdata && !wr_txdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_txdata_q <= 1'b0;
    end else begin
      wr_txdata_q <= wr_txdata;
    end
  end

  // TX FIFO
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push_ok;
  logic             overflow_set;

  assign fifo_full    = (fifo_count == CNT_FULL);
  assign fifo_empty   = (fifo_count == '0);
  // When full, a same-cycle pop frees the slot the push needs.
  assign push_ok      = push_req && (!fifo_full || pop);
  assign overflow_set = push_req && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= memory_data_out[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sticky overflow; a new overflow in the same cycle beats the W1C clear.
  logic overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (overflow_set) begin
      overflow <= 1'b1;
    end else if (wr_status && memory_data_out[3]) begin
      overflow <= 1'b0;
    end
  end

  // Serialiser
  logic [1:0]        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic              tx_reg;
  logic              baud_last;

  assign baud_last = (baud_cnt == BAUD_LAST);
  // STOP pops directly into the next START so queued bytes go out back-to-back.
  assign pop       = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && baud_last));
  assign uart_tx   = tx_reg;
  assign tx_busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          tx_reg <= 1'b1;
          if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
            tx_reg    <= 1'b0;
            baud_cnt  <= '0;
            state     <= S_START;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_reg   <= shift_reg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_reg <= 1'b1;
              state  <= S_STOP;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx_reg    <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (pop) begin
              shift_reg <= fifo_mem[rd_ptr];
              tx_reg    <= 1'b0;
              state     <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          tx_reg <= 1'b1;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // CTRL register and interrupt
  logic [31:0] ctrl_rd;

`ifdef MMIO_UART_TX_IRQ_EN
  logic irq_enable;
  logic wr_ctrl;

  assign wr_ctrl = hit && memory_write_enable && (offset == OFF_CTRL);
  assign ctrl_rd = {31'd0, irq_enable};

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_enable <= 1'b0;
      tx_irq     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        irq_enable <= memory_data_out[0];
      end
      tx_irq <= irq_enable && fifo_empty && (state == S_IDLE);
    end
  end
`else
  assign ctrl_rd = 32'd0;
`endif

  // Read mux
  logic [31:0] status_rd;

  assign status_rd = {21'd0, 7'(fifo_count), overflow, tx_busy, fifo_empty, fifo_full};

  always_comb begin
    read_data = 32'd0;
    if (hit) begin
      case (offset)
        OFF_STATUS: read_data = status_rd;
        OFF_CTRL:   read_data = ctrl_rd;
        default:    read_data = 32'd0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{memory_address[1:0], memory_data_out[31:8]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: bus driver tasks, serial-line monitor with an expected-byte queue,
// directed register/timing checks. Covers the tx_irq path when MMIO_UART_TX_IRQ_EN is defined.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] memory_address = 32'd0;
  logic [31:0] memory_data_out = 32'd0;
  logic        memory_write_enable = 1'b0;
  logic [31:0] read_data;
  logic        hit;
  logic        uart_tx;
  logic        tx_busy;
`ifdef MMIO_UART_TX_IRQ_EN
  logic        tx_irq;
`endif

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .memory_address     (memory_address),
    .memory_data_out    (memory_data_out),
    .memory_write_enable(memory_write_enable),
    .read_data          (read_data),
    .hit                (hit),
    .uart_tx            (uart_tx),
    .tx_busy            (tx_busy)
`ifdef MMIO_UART_TX_IRQ_EN
    ,
    .tx_irq             (tx_irq)
`endif
  );

  // Clock / reset bookkeeping
  always #5 clk = ~clk;

  int cyc = 0;
  int rst_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) rst_cnt <= rst_cnt + 1;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [7:0] exp_q[$];
  int         delta_q[$];
  int         prev_n0 = -1;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks: inputs change just after the falling edge
  task automatic bus_write(input logic [31:0] off, input logic [31:0] d, input int hold);
    @(negedge clk);
    memory_address      = BASE + off;
    memory_data_out     = d;
    memory_write_enable = 1'b1;
    repeat (hold) @(negedge clk);
    memory_write_enable = 1'b0;
    memory_address      = 32'd0;
    memory_data_out     = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] off, output logic [31:0] d, output logic h);
    memory_address = BASE + off;
    #1;
    d = read_data;
    h = hit;
    memory_address = 32'd0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'((exp_q.size() == 0) && (tx_busy === 1'b0)), 32'd1);
  endtask

  // Monitor: decodes frames from the serial line at bit centres and pops expected bytes
  initial begin : monitor
    logic [7:0] b;
    logic       s0;
    logic       s9;
    int         n0;
    int         r0;
    forever begin
      @(negedge clk);
      if (!reset && uart_tx === 1'b0) begin
        n0 = cyc;
        r0 = rst_cnt;
        repeat (CPB / 2) @(negedge clk);
        s0 = uart_tx;
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        s9 = uart_tx;
        if (rst_cnt != r0) begin
          prev_n0 = -1;
        end else begin
          check("start_bit", 32'(s0), 32'd0);
          check("stop_bit", 32'(s9), 32'd1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_unexpected: got byte 0x%02h expected no frame (t=%0t)", b, $time);
          end else begin
            check("frame_byte", 32'(b), 32'(exp_q.pop_front()));
          end
          if (prev_n0 >= 0) delta_q.push_back(n0 - prev_n0);
          prev_n0 = n0;
        end
      end
    end
  end

  // Directed stimulus
  initial begin : stimulus
    logic [31:0] rd;
    logic        h;
    logic [7:0]  bits;
    int          seg;
    int          bad;
    int          n;
    logic        e;

    repeat (3) @(negedge clk);
    check("rst_line", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    reset = 1'b0;
    bus_read(32'h4, rd, h);
    check("rst_status", rd, 32'h2);
    check("rst_status_hit", 32'(h), 32'd1);
    bus_read(32'h0, rd, h);
    check("txdata_reads_zero", rd, 32'h0);

    // Single byte 0x55, cycle-exact line shape
    exp_q.push_back(8'h55);
    bits = 8'h55;
    bus_write(32'h0, 32'h55, 1);
    bus_read(32'h4, rd, h);
    check("t1_status_after_push", rd, 32'h10);
    check("t1_line_before_pop", 32'(uart_tx), 32'd1);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      seg = i / CPB;
      if (seg == 0) e = 1'b0;
      else if (seg == 9) e = 1'b1;
      else e = bits[seg-1];
      check($sformatf("t1_line_c%0d", i), 32'(uart_tx), 32'(e));
      check($sformatf("t1_busy_c%0d", i), 32'(tx_busy), 32'd1);
    end
    @(negedge clk);
    check("t1_busy_after", 32'(tx_busy), 32'd0);
    check("t1_line_after", 32'(uart_tx), 32'd1);
    wait_drain("t1_drain", 4 * FRAME);

    // Strobe held three cycles: one push only
    exp_q.push_back(8'hA5);
    bus_write(32'h0, 32'hA5, 3);
    bus_read(32'h4, rd, h);
    check("t2_status_single_push", rd, 32'h6);
    wait_drain("t2_drain", 4 * FRAME);
    repeat (2 * FRAME) @(negedge clk);
    check("t2_no_second_frame", 32'(tx_busy), 32'd0);

    // Overflow with FIFO of 4 while serialiser busy
    prev_n0 = -1;
    delta_q.delete();
    for (int v = 1; v <= 6; v++) begin
      if (v <= 5) exp_q.push_back(8'(v));
      bus_write(32'h0, 32'(v), 1);
    end
    bus_read(32'h4, rd, h);
    check("t3_full", 32'(rd[0]), 32'd1);
    check("t3_overflow", 32'(rd[3]), 32'd1);
    check("t3_status", rd, 32'h4D);
    bus_write(32'h4, 32'h8, 1);
    bus_read(32'h4, rd, h);
    check("t3_status_after_clear", rd, 32'h45);
    wait_drain("t3_drain", 10 * FRAME);
    check("t3_frame_count", 32'(delta_q.size()), 32'd4);
    for (int i = 0; i < delta_q.size(); i++) begin
      check($sformatf("t3_back_to_back_%0d", i), 32'(delta_q[i]), 32'(FRAME));
    end

    // Reset mid-DATA with three bytes queued
    bus_write(32'h0, 32'h11, 1);
    bus_write(32'h0, 32'h22, 1);
    bus_write(32'h0, 32'h33, 1);
    bus_write(32'h0, 32'h44, 1);
    repeat (5) @(negedge clk);
    check("t4_in_frame", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t4_rst_line", 32'(uart_tx), 32'd1);
    check("t4_rst_busy", 32'(tx_busy), 32'd0);
    bus_read(32'h4, rd, h);
    check("t4_rst_status", rd, 32'h2);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (tx_busy !== 1'b0 || uart_tx !== 1'b1) bad++;
    end
    check("t4_quiet_after_reset", 32'(bad), 32'd0);
    bus_read(32'h4, rd, h);
    check("t4_status_after", rd, 32'h2);

    // Address decode
    bus_read(32'h4, rd, h);
    check("t5_status_idle", rd, 32'h2);
    bus_read(32'hC, rd, h);
    check("t5_hit_0c", 32'(h), 32'd0);
    check("t5_rd_0c", rd, 32'd0);
    bus_read(32'h20, rd, h);
    check("t5_hit_20", 32'(h), 32'd0);
    check("t5_rd_20", rd, 32'd0);
    bus_read(32'h8, rd, h);
    check("t5_hit_08", 32'(h), 32'd1);
    check("t5_ctrl_reset", rd, 32'd0);
    bus_write(32'hC, 32'h77, 1);
    bus_write(32'h20, 32'h78, 1);
    @(negedge clk);
    bus_read(32'h4, rd, h);
    check("t5_no_push_outside", rd, 32'h2);

`ifdef MMIO_UART_TX_IRQ_EN
    // Interrupt on return to idle
    bus_write(32'h8, 32'h1, 1);
    @(negedge clk);
    check("t6_irq_enabled_idle", 32'(tx_irq), 32'd1);
    bus_read(32'h8, rd, h);
    check("t6_ctrl_read", rd, 32'h1);
    exp_q.push_back(8'h3C);
    bus_write(32'h0, 32'h3C, 1);
    @(negedge clk);
    check("t6_irq_drop", 32'(tx_irq), 32'd0);
    n = 0;
    while (tx_busy === 1'b1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("t6_frame_end", 32'(tx_busy), 32'd0);
    check("t6_irq_not_yet", 32'(tx_irq), 32'd0);
    @(negedge clk);
    check("t6_irq_rise", 32'(tx_irq), 32'd1);
    wait_drain("t6_drain", 2 * FRAME);
    bus_write(32'h8, 32'h0, 1);
    @(negedge clk);
    check("t6_irq_disabled", 32'(tx_irq), 32'd0);
`endif

    repeat (4) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
